sample_frame_ctrl: RTL
======================

# sample_frame_ctrl

Frame scheduler between the ADC sampling path and the outbound SPI master. Generates the periodic sample strobe for the ADC SPI reader, collects a fixed-length frame of ADC words into an internal buffer, then drains the frame word-by-word into the SPI master using its ready/valid handshake. Replaces the free-running sampler plus direct ADC-to-SPI wiring at top level, giving the downstream FFT host whole, ordered frames.

## Interface
- SAMPLE_DIV, 1600: clock cycles per sample strobe (10 kHz at 16 MHz); legal range 4..65535.
- FRAME_LEN, 8: words per frame; power of two, 2..64.
- WORD_W, 16: ADC/TX word width.
- i_Clk  in  1  system clock (16 MHz).
- i_Rst  in  1  reset; synchronous, active-high.
- i_Enable  in  1  level; 1 = run acquisition frames.
- o_Sample  out  1  one-cycle strobe to ADC SPI reader SAMPLE input.
- i_ADC_DV  in  1  one-cycle ADC data-valid.
- i_ADC_Data  in  WORD_W  ADC word, qualified by i_ADC_DV.
- o_TX_DV  out  1  one-cycle word strobe to SPI master.
- o_TX_Word  out  WORD_W  word to transmit, valid with o_TX_DV.
- i_TX_Ready  in  1  SPI master idle/ready.
- o_Frame_Done  out  1  one-cycle pulse after last word of a frame is issued.
- o_Overrun  out  1  sticky: ADC word arrived with nowhere to store it.
- o_Busy  out  1  1 in any state other than IDLE.

## Operation
- States: IDLE, ACQUIRE, HEADER (only with macro), DRAIN.
- IDLE: divider held at 0, indices at 0. i_Enable=1 -> ACQUIRE next cycle.
- ACQUIRE: divider counts 0..SAMPLE_DIV-1 and wraps; o_Sample=1 in the cycle count==SAMPLE_DIV-1. Each i_ADC_DV writes buffer[wr_idx], wr_idx++. Write with wr_idx==FRAME_LEN-1 -> DRAIN (or HEADER), wr_idx=0.
- ACQUIRE with i_Enable=0: partial frame discarded, wr_idx=0 -> IDLE.
- DRAIN: issue rule: o_TX_DV=1 only when i_TX_Ready=1 and o_TX_DV was 0 the previous cycle. o_TX_Word=buffer[rd_idx] registered with o_TX_DV; rd_idx++. On issue of rd_idx==FRAME_LEN-1: o_Frame_Done=1 same cycle, rd_idx=0, next state ACQUIRE if i_Enable=1 else IDLE. i_Enable is ignored until the frame finishes draining.
- Divider keeps running in DRAIN/HEADER but o_Sample is suppressed there; on return to ACQUIRE the divider continues from its current value (no phase reset).
- i_ADC_DV outside ACQUIRE: word dropped, o_Overrun set. o_Overrun cleared only by i_Rst.
- i_ADC_DV coinciding with the transition to IDLE on i_Enable=0: dropped, no overrun.
- Buffer: FRAME_LEN x WORD_W register/RAM, words transmitted in capture order, unmodified.

## Timing
- Reset: all outputs 0, state IDLE, divider/indices 0, o_Overrun 0.
- First o_Sample: SAMPLE_DIV cycles after the first ACQUIRE cycle; thereafter every SAMPLE_DIV cycles while in ACQUIRE.
- DRAIN entry: first o_TX_DV no earlier than 1 cycle after the last ADC write, only if i_TX_Ready=1.
- Back-to-back ready: with i_TX_Ready held 1, o_TX_DV at most every other cycle.
- i_Rst mid-frame/mid-drain: immediate return to IDLE next cycle, buffer contents irrelevant, o_TX_DV 0.

## Configuration
- FRAME_HEADER_EN defined: HEADER state between ACQUIRE and DRAIN sends one word 16'hA5A5 (zero-extended/truncated to WORD_W) under the same issue rule, then DRAIN; o_Frame_Done unaffected (fires on last data word). Frame on wire = FRAME_LEN+1 words.
- Not defined: HEADER state absent; ACQUIRE goes straight to DRAIN; FRAME_LEN words per frame.

## Test plan
- SAMPLE_DIV=4, FRAME_LEN=4, reset then i_Enable=1 -> o_Sample pulses at cycles 4, 8, 12, 16 after ACQUIRE entry; none before.
- Feed ADC words 0x0001..0x0004 one cycle after each strobe, i_TX_Ready=1 -> o_TX_DV carries 0x0001,0x0002,0x0003,0x0004 in order, every other cycle; o_Frame_Done with 0x0004; state ACQUIRE.
- Same, i_TX_Ready toggled low 3 cycles after each o_TX_DV -> no o_TX_DV while low; no word lost or duplicated.
- i_ADC_DV pulse during DRAIN -> o_Overrun=1, frame data unchanged, stays 1 until i_Rst.
- i_Enable=0 after 2 captured words -> IDLE, no o_TX_DV; re-enable -> next frame starts at wr_idx 0.
- With FRAME_HEADER_EN -> 0xA5A5 precedes 0x0001..0x0004; i_Rst during DRAIN -> all outputs 0 next cycle, o_Busy=0.

Source files
------------

// File: rtl/sample_frame_ctrl.sv
// sample_frame_ctrl: paces ADC sampling with a periodic strobe, captures a
// frame of FRAME_LEN words, then drains the frame in capture order to an SPI
// master through its ready/valid handshake.
//
// Latency: o_Sample is combinational from state/divider. o_TX_DV, o_TX_Word
// and o_Frame_Done are registered one cycle after i_TX_Ready is seen.
// Backpressure: no word is issued while i_TX_Ready is low, and at most one
// word is issued every other cycle. ADC words that arrive outside ACQUIRE are
// dropped and set the sticky o_Overrun flag.
//
// Ports:
//   i_Clk, i_Rst            clock, synchronous active-high reset
//   i_Enable                level, run acquisition frames
//   o_Sample                one-cycle strobe to the ADC reader
//   i_ADC_DV, i_ADC_Data    ADC word and its qualifier
//   o_TX_DV, o_TX_Word      word strobe and data to the SPI master
//   i_TX_Ready              SPI master ready
//   o_Frame_Done            pulse with the last data word of a frame
//   o_Overrun               sticky, an ADC word had nowhere to go
//   o_Busy                  high in any state other than IDLE
//
// Optional feature (macro FRAME_HEADER_EN): one header word 16'hA5A5 is sent
// ahead of each frame's data words.
module sample_frame_ctrl #(
  parameter int SAMPLE_DIV = 1600,
  parameter int FRAME_LEN  = 8,
  parameter int WORD_W     = 16
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Enable,
  output logic              o_Sample,
  input  logic              i_ADC_DV,
  input  logic [WORD_W-1:0] i_ADC_Data,
  output logic              o_TX_DV,
  output logic [WORD_W-1:0] o_TX_Word,
  input  logic              i_TX_Ready,
  output logic              o_Frame_Done,
  output logic              o_Overrun,
  output logic              o_Busy
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int DIV_W = 16;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
`ifdef FRAME_HEADER_EN
  localparam logic [WORD_W-1:0] HDR_WORD = WORD_W'(16'hA5A5);
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
`ifdef FRAME_HEADER_EN
    S_HEADER  = 2'd3,
`endif
    S_DRAIN   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [WORD_W-1:0] frame_buf [FRAME_LEN];

  logic              wr_en;       // capture i_ADC_Data this cycle
  logic              issue;       // launch a word (header or data) to TX
  logic              issue_data;  // the launched word comes from the buffer
  logic              last_data;   // launched word is the frame's last
  logic              ovr_set;     // ADC word with nowhere to store it
  logic [WORD_W-1:0] tx_word_nxt;

  // Issue rule shared by HEADER and DRAIN: the master must be ready and we
  // must not have strobed last cycle, which gives it a cycle to drop ready.
  logic can_issue;
  assign can_issue = i_TX_Ready && !o_TX_DV;

  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    issue       = 1'b0;
    issue_data  = 1'b0;
    last_data   = 1'b0;
    ovr_set     = 1'b0;
    tx_word_nxt = frame_buf[rd_idx];
    case (state)
      S_IDLE: begin
        ovr_set = i_ADC_DV;
        if (i_Enable) state_nxt = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        // A word arriving together with the disable is silently discarded.
        if (!i_Enable) begin
          state_nxt = S_IDLE;
        end else if (i_ADC_DV) begin
          wr_en = 1'b1;
          if (wr_idx == IDX_LAST) begin
`ifdef FRAME_HEADER_EN
            state_nxt = S_HEADER;
`else
            state_nxt = S_DRAIN;
`endif
          end
        end
      end
`ifdef FRAME_HEADER_EN
      S_HEADER: begin
        ovr_set = i_ADC_DV;
        if (can_issue) begin
          issue       = 1'b1;
          tx_word_nxt = HDR_WORD;
          state_nxt   = S_DRAIN;
        end
      end
`endif
      S_DRAIN: begin
        ovr_set = i_ADC_DV;
        if (can_issue) begin
          issue      = 1'b1;
          issue_data = 1'b1;
          if (rd_idx == IDX_LAST) begin
            last_data = 1'b1;
            state_nxt = i_Enable ? S_ACQUIRE : S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes only while acquiring; the divider itself free-runs outside IDLE.
  assign o_Sample = (state == S_ACQUIRE) && (div_cnt == DIV_LAST);
  assign o_Busy   = (state != S_IDLE);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      o_TX_DV      <= 1'b0;
      o_TX_Word    <= '0;
      o_Frame_Done <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      state <= state_nxt;

      // Held at zero in IDLE so the first strobe lands SAMPLE_DIV cycles
      // into ACQUIRE; not reset between frames so the sample rate is steady.
      if (state == S_IDLE || state_nxt == S_IDLE)
        div_cnt <= '0;
      else if (div_cnt == DIV_LAST)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 1'b1;

      if (state == S_ACQUIRE && state_nxt == S_IDLE)
        wr_idx <= '0;
      else if (wr_en)
        wr_idx <= (wr_idx == IDX_LAST) ? '0 : wr_idx + 1'b1;

      if (issue_data)
        rd_idx <= last_data ? '0 : rd_idx + 1'b1;

      o_TX_DV      <= issue;
      o_Frame_Done <= last_data;
      if (issue) o_TX_Word <= tx_word_nxt;
      if (ovr_set) o_Overrun <= 1'b1;
    end
  end

  // Frame storage carries no reset; contents are only read after a full
  // capture has overwritten every entry.
  always_ff @(posedge i_Clk) begin
    if (wr_en) frame_buf[wr_idx] <= i_ADC_Data;
  end

endmodule
